// File: rtl/proc_pkg.sv
// Shared processor definitions: bus controller state encoding, region codes
// and the default memory map.
package proc_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        SETUP  = 4'b0010,
        STROBE = 4'b0100,
        DONE   = 4'b1000
    } state_t;

    typedef enum logic [1:0] {
        REG_RAM = 2'd0,
        REG_IO  = 2'd1,
        REG_ROM = 2'd2
    } region_t;

    localparam int unsigned DEF_RAM_WAIT = 0;
    localparam int unsigned DEF_ROM_WAIT = 1;
    localparam int unsigned DEF_IO_WAIT  = 2;

    localparam logic [15:0] DEF_RAM_TOP = 16'h7FFF;
    localparam logic [15:0] DEF_IO_BASE = 16'h8000;
    localparam logic [15:0] DEF_IO_TOP  = 16'h80FF;

endpackage

// File: rtl/bus_ctrl_if.sv
// Core-side request/acknowledge bus between the 6502 core (master) and the
// memory bus controller (slave).
interface bus_ctrl_if;

    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ack;
    logic        err;
    logic        busy;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack, err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack, err, busy
    );

endinterface

// File: rtl/bus_ctrl_decode.sv
// Address decoder: maps a core address to its memory region and the number
// of extra strobe cycles that region needs.
module bus_decode
    import proc_pkg::*;
#(
    parameter int unsigned RAM_WAIT = DEF_RAM_WAIT,
    parameter int unsigned ROM_WAIT = DEF_ROM_WAIT,
    parameter int unsigned IO_WAIT  = DEF_IO_WAIT,
    parameter logic [15:0] RAM_TOP  = DEF_RAM_TOP,
    parameter logic [15:0] IO_BASE  = DEF_IO_BASE,
    parameter logic [15:0] IO_TOP   = DEF_IO_TOP
) (
    input  logic [15:0] addr,
    output region_t     region,
    output logic [2:0]  wait_cnt
);

    // RAM wins over I/O if the windows are ever configured to overlap.
    always_comb begin
        region   = REG_ROM;
        wait_cnt = 3'(ROM_WAIT);
        if (addr <= RAM_TOP) begin
            region   = REG_RAM;
            wait_cnt = 3'(RAM_WAIT);
        end else if ((addr >= IO_BASE) && (addr <= IO_TOP)) begin
            region   = REG_IO;
            wait_cnt = 3'(IO_WAIT);
        end
    end

endmodule

// File: rtl/bus_ctrl.sv
// Memory bus controller: turns single-byte core requests into chip-enable,
// output-enable and write strobes with per-region wait states.
module bus_ctrl
    import proc_pkg::*;
#(
    parameter int unsigned RAM_WAIT = DEF_RAM_WAIT,
    parameter int unsigned ROM_WAIT = DEF_ROM_WAIT,
    parameter int unsigned IO_WAIT  = DEF_IO_WAIT,
    parameter logic [15:0] RAM_TOP  = DEF_RAM_TOP,
    parameter logic [15:0] IO_BASE  = DEF_IO_BASE,
    parameter logic [15:0] IO_TOP   = DEF_IO_TOP
) (
    input  logic        clk,
    input  logic        resetn,
    bus_ctrl_if.slave   core,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        mem_ce_ram,
    output logic        mem_ce_io,
    output logic        mem_ce_rom,
    output logic        mem_oe,
    output logic        mem_we
);

    if ((RAM_WAIT > 7) || (ROM_WAIT > 7) || (IO_WAIT > 7)) begin : g_wait_range
        $error("bus_ctrl: wait-state parameters must be in the range 0..7");
    end

    state_t      state, state_nxt;
    region_t     dec_region, region_q;
    logic [2:0]  dec_wait, wcnt;
    logic        we_q;
    logic [7:0]  rdata_q;
    logic        ce_act;
    logic        oe_nxt, we_nxt, ack_nxt, err_nxt;

    bus_decode #(
        .RAM_WAIT (RAM_WAIT),
        .ROM_WAIT (ROM_WAIT),
        .IO_WAIT  (IO_WAIT),
        .RAM_TOP  (RAM_TOP),
        .IO_BASE  (IO_BASE),
        .IO_TOP   (IO_TOP)
    ) u_decode (
        .addr     (core.addr),
        .region   (dec_region),
        .wait_cnt (dec_wait)
    );

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            we_q      <= 1'b0;
            region_q  <= REG_RAM;
            wcnt      <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (core.req) begin
                        we_q      <= core.we;
                        region_q  <= dec_region;
                        wcnt      <= dec_wait;
                        mem_addr  <= core.addr;
                        mem_wdata <= core.wdata;
                    end
                end
                STROBE: begin
                    if (wcnt != '0)
                        wcnt <= wcnt - 3'd1;
                    else if (!we_q)
                        rdata_q <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        ce_act    = 1'b0;
        oe_nxt    = 1'b0;
        we_nxt    = 1'b0;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (core.req) state_nxt = SETUP;
            end
            SETUP: begin
                ce_act    = 1'b1;
                state_nxt = STROBE;
            end
            STROBE: begin
                ce_act = 1'b1;
                oe_nxt = !we_q;
                // ROM cannot be written: keep the strobe quiet, flag it at DONE.
                we_nxt = we_q && (region_q != REG_ROM);
                if (wcnt == '0) state_nxt = DONE;
            end
            DONE: begin
                ack_nxt   = 1'b1;
                err_nxt   = we_q && (region_q == REG_ROM);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_ce_ram = ce_act && (region_q == REG_RAM);
    assign mem_ce_io  = ce_act && (region_q == REG_IO);
    assign mem_ce_rom = ce_act && (region_q == REG_ROM);
    assign mem_oe     = oe_nxt;
    assign mem_we     = we_nxt;

    assign core.rdata = rdata_q;
    assign core.ack   = ack_nxt;
    assign core.err   = err_nxt;
    assign core.busy  = (state != IDLE);

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed bench for bus_ctrl with a scoreboard of expected transaction results.
module tb_bus_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ce_ram, mem_ce_io, mem_ce_rom, mem_oe, mem_we;

    always #5 clk = ~clk;

    bus_ctrl_if bus ();

    bus_ctrl #(
        .RAM_WAIT (0),
        .ROM_WAIT (1),
        .IO_WAIT  (2),
        .RAM_TOP  (16'h7FFF),
        .IO_BASE  (16'h8000),
        .IO_TOP   (16'h80FF)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .core       (bus),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ce_ram (mem_ce_ram),
        .mem_ce_io  (mem_ce_io),
        .mem_ce_rom (mem_ce_rom),
        .mem_oe     (mem_oe),
        .mem_we     (mem_we)
    );

    // Memory contents are a fixed function of the address (0x0010 -> 0xA5).
    function automatic logic [7:0] mem_model(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hB5;
    endfunction

    assign mem_rdata = mem_model(mem_addr);

    // Region codes used by the bench: 1 RAM, 2 I/O, 3 ROM, 0 none.
    function automatic int exp_region(input logic [15:0] a);
        if (a <= 16'h7FFF) return 1;
        if ((a >= 16'h8000) && (a <= 16'h80FF)) return 2;
        return 3;
    endfunction

    function automatic int exp_wait(input int r);
        if (r == 1) return 0;
        if (r == 2) return 2;
        return 1;
    endfunction

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         lat;
        int         ce_n;
        int         strb_n;
        int         region;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] last_rd = 8'h00;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input string tag, input logic w, input logic [15:0] a, input logic [7:0] d);
        exp_t e, g;
        int   r, wt, n;
        int   ce_n = 0, oe_n = 0, we_n = 0, busy_n = 0;
        int   addr_bad = 0, wd_bad = 0, multi = 0, ce_reg = 0;
        logic got_ack = 1'b0;

        r        = exp_region(a);
        wt       = exp_wait(r);
        e.region = r;
        e.lat    = 3 + wt;
        e.ce_n   = 2 + wt;
        e.strb_n = (w && r == 3) ? 0 : 1 + wt;
        e.err    = w && (r == 3);
        e.rdata  = w ? last_rd : mem_model(a);
        if (!w) last_rd = e.rdata;
        sb.push_back(e);

        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
        @(posedge clk);
        #1;
        bus.req = 1'b0; bus.we = ~w; bus.addr = 16'($urandom); bus.wdata = 8'($urandom);

        for (int k = 1; k <= 16 && !got_ack; k++) begin
            @(negedge clk);
            if (bus.busy) busy_n++;
            n = int'(mem_ce_ram) + int'(mem_ce_io) + int'(mem_ce_rom);
            if (n > 1) multi++;
            if (mem_ce_ram) ce_reg = 1;
            if (mem_ce_io)  ce_reg = 2;
            if (mem_ce_rom) ce_reg = 3;
            if (n != 0) begin
                ce_n++;
                if (mem_addr !== a) addr_bad++;
            end
            if (mem_oe) oe_n++;
            if (mem_we) begin
                we_n++;
                if (mem_wdata !== d) wd_bad++;
            end
            if (bus.ack) begin
                got_ack = 1'b1;
                g = sb.pop_front();
                check({tag, ".ack_cycle"}, k, g.lat);
                check({tag, ".rdata"}, 32'(bus.rdata), 32'(g.rdata));
                check({tag, ".err"}, 32'(bus.err), 32'(g.err));
                check({tag, ".region"}, ce_reg, g.region);
                check({tag, ".ce_cycles"}, ce_n, g.ce_n);
                check({tag, ".strobe_cycles"}, w ? we_n : oe_n, g.strb_n);
                check({tag, ".other_strobe"}, w ? oe_n : we_n, 0);
                check({tag, ".busy_cycles"}, busy_n, g.lat);
                check({tag, ".addr_bad"}, addr_bad, 0);
                check({tag, ".multi_ce"}, multi, 0);
                if (w) check({tag, ".wdata_bad"}, wd_bad, 0);
            end
        end
        if (!got_ack) begin
            check({tag, ".ack_timeout"}, 0, 1);
            if (sb.size() != 0) void'(sb.pop_front());
        end
        @(negedge clk);
        check({tag, ".busy_after"}, 32'(bus.busy), 0);
        check({tag, ".ack_after"}, 32'(bus.ack), 0);
    endtask

    initial begin
        int acks;
        resetn = 1'b0;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        repeat (3) @(negedge clk);
        check("reset.strobes",
              32'({mem_ce_ram, mem_ce_io, mem_ce_rom, mem_oe, mem_we, bus.ack, bus.err, bus.busy}), 0);
        check("reset.mem_addr", 32'(mem_addr), 0);
        check("reset.mem_wdata", 32'(mem_wdata), 0);
        check("reset.rdata", 32'(bus.rdata), 0);
        resetn = 1'b1;
        @(negedge clk);

        run_txn("ram_rd",   1'b0, 16'h0010, 8'h00);
        run_txn("rom_vec",  1'b0, 16'hFFFC, 8'h00);
        run_txn("io_wr",    1'b1, 16'h8004, 8'h3C);
        run_txn("rom_wr",   1'b1, 16'hE000, 8'h77);
        run_txn("bnd_7fff", 1'b0, 16'h7FFF, 8'h00);
        run_txn("bnd_8000", 1'b0, 16'h8000, 8'h00);
        run_txn("bnd_80ff", 1'b0, 16'h80FF, 8'h00);
        run_txn("bnd_8100", 1'b0, 16'h8100, 8'h00);

        // Abort an I/O read in STROBE with reset.
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h8010; bus.wdata = 8'h00;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort.in_strobe", 32'({mem_ce_io, mem_oe}), 32'h3);
        resetn = 1'b0;
        @(negedge clk);
        check("abort.strobes",
              32'({mem_ce_ram, mem_ce_io, mem_ce_rom, mem_oe, mem_we, bus.ack, bus.err, bus.busy}), 0);
        check("abort.mem_addr", 32'(mem_addr), 0);
        check("abort.rdata", 32'(bus.rdata), 0);
        resetn = 1'b1;
        last_rd = 8'h00;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ack) acks++;
        end
        check("abort.no_ack", acks, 0);

        run_txn("post_wr", 1'b1, 16'h1234, 8'h5A);
        run_txn("post_rd", 1'b0, 16'h1234, 8'h00);
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bus_ctrl.md
# bus_ctrl

Memory bus controller between the 6502 core and external memory. It accepts single-byte read/write requests from the core over a req/ack handshake. It decodes the 16-bit address into RAM, I/O or ROM regions and drives the chip-enable, output-enable and write strobes with per-region wait states. It returns read data with a one-cycle acknowledge.

## Interface
- RAM_WAIT, 0, extra strobe cycles for RAM accesses (0-7)
- ROM_WAIT, 1, extra strobe cycles for ROM accesses (0-7)
- IO_WAIT, 2, extra strobe cycles for I/O accesses (0-7)
- RAM_TOP, 16'h7FFF, highest RAM address; RAM spans 16'h0000..RAM_TOP
- IO_BASE, 16'h8000, lowest I/O address
- IO_TOP, 16'h80FF, highest I/O address; all other addresses decode to ROM, including vectors 16'hFFFA..16'hFFFF
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- req  in  1  core request, level; sampled only in IDLE
- we  in  1  1 = write, 0 = read; latched with req
- addr  in  16  core address; latched with req
- wdata  in  8  write data; latched with req
- rdata  out  8  read data; valid while ack=1, then held until the next read completes
- ack  out  1  one-cycle pulse that completes the transaction
- err  out  1  pulses with ack when the transaction was a write to ROM
- busy  out  1  high in any state other than IDLE
- mem_addr  out  16  memory address
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data
- mem_ce_ram, mem_ce_io, mem_ce_rom  out  1 each  active-high chip enables; at most one is high at a time
- mem_oe  out  1  output enable, asserted for reads
- mem_we  out  1  write strobe, asserted for writes

## Operation
- States: IDLE, SETUP, STROBE, DONE.
- IDLE, req=1: latch we, addr and wdata; decode the region; load wcnt with that region's wait value; go to SETUP. With req=0, stay in IDLE.
- SETUP: drive mem_addr, mem_wdata and the region's CE. mem_oe and mem_we stay low. Go to STROBE.
- STROBE: hold the address and CE. Assert mem_oe for a read or mem_we for a write.
  - A write to ROM suppresses mem_we; mem_oe stays low as well.
  - If wcnt≠0, decrement wcnt and stay in STROBE.
  - If wcnt=0: for a read, capture mem_rdata into rdata on this edge; go to DONE.
- DONE: ack=1, err=1 only for a ROM write. Deassert CE, oe and we. mem_addr holds its last value. Always go to IDLE; req is ignored in DONE.
- Decode priority: addr≤RAM_TOP selects RAM; else IO_BASE≤addr≤IO_TOP selects I/O; else ROM.
- wcnt is 3 bits. Wait parameter values above 7 are illegal and are checked by an elaboration assertion.
- Core inputs may change freely after the accept edge. The latched copies are the ones used.

## Timing
- Reset (resetn=0 at an edge): state becomes IDLE. mem_addr=0, mem_wdata=0, rdata=0. All CE, mem_oe, mem_we, ack, err and busy = 0.
- Reset mid-transaction aborts it with no ack. All strobes drop on the same edge.
- Request sampled at edge t (cycle t). SETUP occupies cycle t+1. STROBE occupies cycles t+2..t+2+W. ack is high in cycle t+3+W.
- RAM read with W=0: ack arrives 3 cycles after acceptance, and rdata equals mem_rdata as seen in cycle t+2.
- Minimum issue interval is 4+W cycles: a new request can be accepted no earlier than the cycle after ack.
- busy rises in the cycle after acceptance and falls in the cycle after ack.
- CE is high for exactly 1+(1+W) cycles per access. mem_we/mem_oe are high for exactly 1+W cycles.

## Structure
- proc_pkg holds the state encoding (one-hot, 4 bits), the region codes (REG_RAM, REG_IO, REG_ROM) and the default memory-map constants. These are shared with the core.
- One sub-module, bus_decode: combinational; maps addr to region and wait count using the parameters.

## Test plan
- RAM read at 16'h0010 with mem_rdata=8'hA5 and defaults -> mem_ce_ram and mem_oe high in cycle t+2; ack in t+3 with rdata=8'hA5 and err=0.
- ROM read of reset vector 16'hFFFC, ROM_WAIT=1 -> mem_ce_rom for 3 cycles; ack at t+4; rdata equals the ROM byte.
- I/O write at 16'h8004 with wdata=8'h3C, IO_WAIT=2 -> mem_we high for exactly 3 cycles with mem_wdata=8'h3C; ack at t+5.
- ROM write at 16'hE000 -> mem_we never asserts; ack and err both pulse at t+4.
- Decode boundaries: addresses 16'h7FFF, 16'h8000, 16'h80FF and 16'h8100 -> select RAM, I/O, I/O and ROM respectively.
- resetn=0 during STROBE of an I/O read -> next cycle all strobes low, busy=0, no ack. A following req completes normally.
